// File: rtl/mine_placer.sv
// Mine placer for the 4x4 board: fills the mine bitmap from a free-running LFSR
// and answers combinational is-mine / adjacent-count queries for any cell.
module mine_placer #(
  parameter int         NUM_MINES = 3,
  parameter logic [7:0] SEED      = 8'h01
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  output logic        place_done,
  output logic        busy,
  output logic [15:0] mine_map,
  output logic [3:0]  mine_count,
  input  logic [3:0]  cell_addr,
  output logic        cell_is_mine,
  output logic [3:0]  adj_count
);

  // state | meaning
  // IDLE  | waiting for start, no map requested yet
  // CLEAR | one cycle wiping the previous map
  // PICK  | drawing one LFSR nibble per cycle until enough mines are set
  // DONE  | complete map held stable
  typedef enum logic [1:0] {IDLE, CLEAR, PICK, DONE} state_t;

  localparam int         N_MINES  = (NUM_MINES < 1) ? 1 : ((NUM_MINES > 15) ? 15 : NUM_MINES);
  localparam logic [3:0] N_TARGET = 4'(N_MINES);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  state_t     state;
  logic [7:0] lfsr;
  logic [3:0] cand;
  logic [3:0] count_next;

  assign cand       = lfsr[3:0];
  assign count_next = mine_count + 4'd1;

  always_ff @(posedge clka) begin
    if (restart) begin
      state      <= IDLE;
      mine_map   <= '0;
      mine_count <= '0;
      lfsr       <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        IDLE: if (start) state <= CLEAR;
        CLEAR: begin
          mine_map   <= '0;
          mine_count <= '0;
          state      <= PICK;
        end
        PICK: begin
          // an already-occupied candidate is simply skipped; the next nibble is tried
          if (!mine_map[cand]) begin
            mine_map[cand] <= 1'b1;
            mine_count     <= count_next;
            if (count_next == N_TARGET) state <= DONE;
          end
        end
        DONE: if (start) state <= CLEAR;
        default: state <= IDLE;
      endcase
    end
  end

  assign place_done   = (state == DONE);
  assign busy         = (state == CLEAR) || (state == PICK);
  assign cell_is_mine = mine_map[cell_addr];

  // neighbours are cells within one row and one column, no wrap at the edges
  always_comb begin
    int dr;
    int dc;
    adj_count = '0;
    dr = 0;
    dc = 0;
    for (int j = 0; j < 16; j++) begin
      dr = (j / 4) - int'(cell_addr[3:2]);
      dc = (j % 4) - int'(cell_addr[1:0]);
      if ((j != int'(cell_addr)) && (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1)
          && mine_map[j])
        adj_count = adj_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: deterministic layout, neighbour counts,
// restart/start interaction and a 15-mine saturation run on a second instance.
module tb_mine_placer;

  logic        clka = 1'b0;
  logic        restart;
  logic        start, start_s;
  logic        place_done, busy, place_done_s, busy_s;
  logic [15:0] mine_map, mine_map_s;
  logic [3:0]  mine_count, mine_count_s;
  logic [3:0]  cell_addr, cell_addr_s;
  logic        cell_is_mine, cell_is_mine_s;
  logic [3:0]  adj_count, adj_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clka = ~clka;

  mine_placer #(.NUM_MINES(3), .SEED(8'h01)) u_dut (
    .clka(clka), .restart(restart), .start(start),
    .place_done(place_done), .busy(busy),
    .mine_map(mine_map), .mine_count(mine_count),
    .cell_addr(cell_addr), .cell_is_mine(cell_is_mine), .adj_count(adj_count)
  );

  mine_placer #(.NUM_MINES(15), .SEED(8'h01)) u_sat (
    .clka(clka), .restart(restart), .start(start_s),
    .place_done(place_done_s), .busy(busy_s),
    .mine_map(mine_map_s), .mine_count(mine_count_s),
    .cell_addr(cell_addr_s), .cell_is_mine(cell_is_mine_s), .adj_count(adj_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // neighbour table for map 16'h0112 (mines at cells 1, 4, 8)
  logic [3:0] q_addr [4] = '{4'd0, 4'd5, 4'd15, 4'd4};
  logic       q_mine [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] q_adj  [4] = '{4'd2, 4'd3, 4'd0, 4'd2};

  initial begin
    int waited;
    restart = 1'b1; start = 1'b0; start_s = 1'b0;
    cell_addr = '0; cell_addr_s = '0;
    tick(); tick();
    check("rst_map", mine_map, 16'h0);
    check("rst_count", mine_count, 4'd0);
    check("rst_done", place_done, 1'b0);
    check("rst_busy", busy, 1'b0);

    // deterministic placement, start held high through PICK
    restart = 1'b0; start = 1'b1;
    tick();                                   // E0
    check("e0_busy", busy, 1'b1);
    tick(); tick(); tick();                   // E1..E3
    check("e3_done_low", place_done, 1'b0);
    check("e3_count", mine_count, 4'd2);
    tick();                                   // E4
    start = 1'b0;
    check("det_done", place_done, 1'b1);
    check("det_map", mine_map, 16'h0112);
    check("det_count", mine_count, 4'd3);
    check("det_busy", busy, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cell_addr = q_addr[i];
      #1;
      check($sformatf("is_mine_c%0d", q_addr[i]), cell_is_mine, q_mine[i]);
      check($sformatf("adj_c%0d", q_addr[i]), adj_count, q_adj[i]);
    end

    // re-place from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rep_busy", busy, 1'b1);
    check("rep_done_low", place_done, 1'b0);
    tick();
    check("rep_map_clr", mine_map, 16'h0);
    check("rep_count_clr", mine_count, 4'd0);
    waited = 0;
    while (!place_done && waited < 2 + 255 * 3) begin
      tick();
      waited++;
    end
    check("rep_done", place_done, 1'b1);
    check("rep_pop", $countones(mine_map), 3);
    check("rep_count", mine_count, 4'd3);

    // restart mid-PICK after one mine
    restart = 1'b1; tick();
    restart = 1'b0; start = 1'b1; tick();     // E0
    start = 1'b0;
    tick(); tick();                           // E1, E2: cell 4 placed
    check("mid_count1", mine_count, 4'd1);
    check("mid_map1", mine_map, 16'h0010);
    restart = 1'b1; tick();
    check("mid_rst_map", mine_map, 16'h0);
    check("mid_rst_count", mine_count, 4'd0);
    check("mid_rst_done", place_done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    // LFSR back at seed: same layout again
    restart = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("reseed_map", mine_map, 16'h0112);
    check("reseed_done", place_done, 1'b1);

    // restart and start on the same edge
    restart = 1'b1; start = 1'b1; tick();
    restart = 1'b0; start = 1'b0;
    check("rs_busy", busy, 1'b0);
    check("rs_done", place_done, 1'b0);
    tick();
    check("rs_idle_busy", busy, 1'b0);
    check("rs_idle_map", mine_map, 16'h0);

    // saturation on the 15-mine instance
    start_s = 1'b1; tick(); start_s = 1'b0;
    waited = 0;
    while (!place_done_s && waited < 2 + 255 * 15) begin
      tick();
      waited++;
      if ($countones(mine_map_s) != int'(mine_count_s))
        check("sat_pop_track", $countones(mine_map_s), mine_count_s);
    end
    check("sat_done", place_done_s, 1'b1);
    check("sat_pop", $countones(mine_map_s), 15);
    check("sat_count", mine_count_s, 4'd15);
    check("sat_busy", busy_s, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
- Populates the 4x4 mine map when the main control FSM pulses `start`.
- Returns `place_done` to the FSM, which waits on `place_done & data_in` before it loads user input.
- Owns the board's mine bitmap and answers combinational cell queries: is-mine and adjacent-mine count, consumed by the decode/ALU stages.
- Randomness comes from a free-running 8-bit LFSR, so the user's timing of `place` varies the layout.

Parameters:
- NUM_MINES, 3, mines to place. Legal range 1..15; out-of-range values are clamped to 15 (0 is treated as 1).
- SEED, 8'h01, LFSR reset value. A value of 0 is replaced by 8'h01.

Ports:
- clka  in  1  single system clock; all state changes on posedge clka
- restart  in  1  synchronous active-high reset
- start  in  1  placement request, level-sampled each cycle
- place_done  out  1  high while a complete map is held (state DONE)
- busy  out  1  high in CLEAR or PICK
- mine_map  out  16  bit i set = mine at cell i; cell = row*4+col
- mine_count  out  4  mines placed so far
- cell_addr  in  4  query cell; row = cell_addr[3:2], col = cell_addr[1:0]
- cell_is_mine  out  1  combinational: mine_map[cell_addr]
- adj_count  out  4  combinational: mines among the up-to-8 neighbours of cell_addr, range 0..8

Behaviour:
- Reset (restart=1 at posedge), regardless of state, even mid-PICK:
  - state=IDLE, mine_map=0, mine_count=0, place_done=0, busy=0, lfsr=SEED (or 8'h01 if SEED=0).
  - A start coincident with restart is ignored.
- LFSR:
  - Fibonacci form: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances on every non-reset clock in all states; period 255; never reaches zero.
- States: IDLE, CLEAR, PICK, DONE.
- IDLE: start=1 -> CLEAR. Otherwise stay.
- CLEAR (one cycle): mine_map<=0, mine_count<=0 -> PICK.
- PICK:
  - cand = current lfsr[3:0], i.e. the pre-advance value at this edge.
  - If mine_map[cand]==0: set the bit and increment mine_count. If the new count == NUM_MINES -> DONE, else stay in PICK.
  - If mine_map[cand]==1: reject and stay; mine_count is unchanged.
  - start is ignored while in PICK.
- DONE:
  - place_done=1; mine_map is held stable.
  - start=1 -> CLEAR (re-place). Otherwise stay.
- Outputs:
  - place_done and busy are decoded from the registered state; no combinational path from start.
- Latency:
  - start sampled at edge E0 -> CLEAR after E0 -> PICK after E1.
  - With no rejections, the last mine is set at edge E(NUM_MINES+1); place_done is high from the cycle after it.
  - Minimum = NUM_MINES+2 edges.
  - Worst case is bounded by the LFSR period (every nibble value appears within 255 steps): placement completes within 2+255*NUM_MINES edges.
- adj_count:
  - Sums mine_map over neighbours (r±1, c±1) that lie inside the 0..3 row/col range; no wrap-around.
  - The query cell itself is excluded.
  - Valid in every state; it reflects a partial map during PICK.
- cell_is_mine and adj_count are purely combinational from cell_addr and the mine_map register.

Test Plan:
- Deterministic placement (SEED=8'h01, NUM_MINES=3): deassert restart, assert start on the first edge -> picks cells 4, 8, 1; mine_map=16'h0112; mine_count=3; place_done rises exactly 5 edges after start is sampled.
- Saturation (NUM_MINES=15): start -> place_done within 2+255*15 edges; popcount(mine_map)=15; mine_count=15; no bit set twice; busy low once DONE.
- Neighbour counts (mine_map=16'h0112 from the deterministic test):
  - cell_addr=0 -> cell_is_mine=0, adj_count=2 (cells 1 and 4)
  - cell_addr=5 -> 3
  - cell_addr=15 -> 0
  - cell_addr=4 -> cell_is_mine=1, adj_count=2
- Reset mid-operation: restart asserted during PICK after 1 mine -> next cycle state=IDLE, mine_map=0, mine_count=0, place_done=0, lfsr=8'h01.
- Start handling: start held high throughout PICK -> no restart of placement. Start pulsed in DONE -> CLEAR; mine_map=0 one cycle later; a new map completes with place_done re-asserted.
- Restart+start same edge -> stays IDLE, place_done=0.
